uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit-side UART controller between the core's memory-mapped UART store path and the board TX pin. Accepts single-cycle byte-write strobes from the RAM/MMIO decode (`uart_te`, `uart_txd`) and buffers them in a FIFO, because the single-cycle core cannot stall. Serialises each byte as 8N1 frames at a fixed baud divisor and exposes status flags for software polling.

## Interface
- `CLKS_PER_BIT`, 868, CLK cycles per serial bit (100 MHz / 115200); legal values ≥ 2
- `FIFO_DEPTH`, 16, byte entries; power of two, ≥ 2
- `CLK` input 1: single clock; all logic on its rising edge
- `RST` input 1: synchronous, active-high reset
- `uart_te` input 1: write strobe, one byte per asserted cycle
- `uart_txd` input 8: byte to transmit, sampled when `uart_te`=1
- `ovf_clr` input 1: clears `ovf` sticky flag
- `tx` output 1: serial line, idle high; registered
- `busy` output 1: frame in progress or FIFO non-empty
- `fifo_full` output 1: FIFO holds FIFO_DEPTH entries
- `fifo_count` output $clog2(FIFO_DEPTH)+1: current occupancy
- `ovf` output 1: sticky, a write was dropped

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `fifo_count`=0, `ovf`=0; FSM=IDLE; FIFO pointers 0.
- FIFO: write pointer advances on accepted write; read pointer on pop; pointers wrap modulo FIFO_DEPTH; count tracks occupancy.
- Write with FIFO full and no pop in the same cycle: byte dropped, `ovf` set at that edge. Write while full with a pop in the same cycle: accepted (count unchanged).
- `ovf_clr` and a dropping write in the same cycle: `ovf` ends at 1 (set wins).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO non-empty: pop head into shift register, load baud counter with CLKS_PER_BIT-1, `tx`←0, go START.
  - START/DATA/STOP: baud counter decrements each cycle; at 0 the bit ends.
  - START end: `tx`←shift[0] (LSB first), bit index←0, go DATA.
  - DATA end: if bit index=7, `tx`←1, go STOP; else shift right, `tx`←next bit, index+1.
  - STOP end: if FIFO non-empty, pop and go START with `tx`←0 at the same edge (no idle gap); else go IDLE.
- Writes arriving mid-frame queue normally; the frame in flight is never modified.
- `RST` mid-frame: frame abandoned, `tx`=1 at next edge, FIFO emptied, `ovf` cleared.

## Timing
- Write accepted at edge E0 (FIFO previously empty, FSM IDLE) → pop and `tx` falls at edge E1; start bit occupies cycles E1..E1+CLKS_PER_BIT-1.
- Each bit exactly CLKS_PER_BIT cycles; frame = 10×CLKS_PER_BIT cycles; back-to-back frames with no gap.
- `fifo_count`, `fifo_full`, `ovf` update at the edge of the causing event (visible one cycle after the strobe).
- `busy` is combinational from FSM≠IDLE or count≠0; it falls in the cycle after the STOP bit ends with FIFO empty.

## Structure
- Shared `defs.v`: FSM state encodings (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`) and default CLKS_PER_BIT/FIFO_DEPTH constants.
- One sub-module: `uart_tx_fifo` (synchronous FIFO with push/pop/full/empty/count, same CLK/RST). Baud counter, bit counter, shift register and FSM stay in `uart_tx_ctrl`.
- Expected size: ~250 lines total.

## Test plan
(CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
- Reset, then a single write of 0xA5 at E0 → `tx` low from E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; `busy` falls at cycle E1+40.
- Six writes on consecutive cycles (0x01..0x06) → first pops at E1; FIFO fills; 6th write dropped, `ovf`=1; line shows 0x01..0x05 back-to-back with no idle gap between frames.
- Write while `fifo_full` in the same cycle as a STOP-end pop → byte accepted, `fifo_count` stays 4, `ovf` stays 0.
- `ovf_clr` asserted together with a dropping write → `ovf`=1; `ovf_clr` alone next cycle → `ovf`=0.
- `RST` asserted mid-DATA of 0x55 with 2 bytes queued → next edge `tx`=1, `fifo_count`=0, `busy`=0; after release no residual frame is sent.
- FIFO_DEPTH=4, 9 bytes written spaced ≥ 1 frame apart → pointers wrap twice; received byte stream matches written stream exactly.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: FSM states and default sizing.
package uart_tx_ctrl_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 868;
  localparam int unsigned DEF_FIFO_DEPTH   = 16;
  localparam int unsigned DATA_W           = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// Synchronous byte FIFO buffering store-path writes ahead of the serialiser.
module uart_tx_fifo
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count_d;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is taken only when the head leaves at the same edge.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_d = count;
    if (do_push && !do_pop) begin
      count_d = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign head_c = mem[rptr];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers single-cycle byte strobes and sends 8N1 frames.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          uart_te,
  input  logic [7:0]                    uart_txd,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_d;
  logic              ovf_d;
  logic              pop_c;
  logic              fifo_empty;
  logic [7:0]        head_c;
  logic              bit_end;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .push   (uart_te),
    .pop    (pop_c),
    .wdata  (uart_txd),
    .head_c (head_c),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bit_end = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q - BAUD_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx;
    pop_c   = 1'b0;
    case (state_q)
      UART_IDLE: begin
        tx_d   = 1'b1;
        baud_d = baud_q;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = head_c;
          baud_d  = BAUD_LOAD;
          tx_d    = 1'b0;
          state_d = UART_START;
        end
      end
      UART_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          idx_d   = 3'd0;
          baud_d  = BAUD_LOAD;
          state_d = UART_DATA;
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          baud_d = BAUD_LOAD;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = UART_STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      UART_STOP: begin
        // Chain straight into the next start bit so queued bytes leave without a gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = head_c;
            baud_d  = BAUD_LOAD;
            tx_d    = 1'b0;
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // A dropped write outranks a same-cycle clear so the loss is never hidden.
  always_comb begin
    ovf_d = ovf;
    if (uart_te && fifo_full && !pop_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      ovf     <= ovf_d;
    end
  end

  assign busy = (state_q != UART_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: cycle tables, line decoder and byte scoreboard.
module tb_uart_tx_ctrl;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       uart_te;
  logic [7:0] uart_txd;
  logic       ovf_clr;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       ovf;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .uart_te    (uart_te),
    .uart_txd   (uart_txd),
    .ovf_clr    (ovf_clr),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .ovf        (ovf)
  );

  typedef struct {
    logic       te;
    logic [7:0] d;
    logic       clr;
    logic       acc;
    logic [2:0] cnt;
    logic       full;
    logic       ovf;
  } vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         frames = 0;
  int         rx_n = -1;
  logic [7:0] rx_byte = '0;
  logic [7:0] sb[$];
  int         starts[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line decoder: sampled at falling edges, two cycles into each bit cell.
  always @(negedge CLK) begin
    if (RST) begin
      rx_n = -1;
    end else if (rx_n < 0) begin
      if (tx === 1'b0) begin
        rx_n = 0;
        starts.push_back(cyc);
      end
    end else begin
      rx_n++;
      if (rx_n == 2) check("rx_start_bit", 32'(tx), 32'd0);
      if (rx_n >= 6 && rx_n <= 34 && (rx_n - 6) % 4 == 0) rx_byte = {tx, rx_byte[7:1]};
      if (rx_n == 38) begin
        frames++;
        check("rx_stop_bit", 32'(tx), 32'd1);
        if (sb.size() == 0) begin
          check("rx_unexpected_frame", 32'(rx_byte), 32'hFFFF_FFFF);
        end else begin
          check("rx_byte", 32'(rx_byte), 32'(sb.pop_front()));
        end
        rx_n = -1;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic te, input logic [7:0] d, input logic clr);
    uart_te  = te;
    uart_txd = d;
    ovf_clr  = clr;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    RST = 1'b0;
    sb.delete();
    starts.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || rx_n >= 0) && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[10];
    logic [7:0] pat;
    logic [7:0] b;
    logic       exp_tx;
    logic       low_seen;
    int         f0;

    RST = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    check("reset_tx",    32'(tx),         32'd1);
    check("reset_busy",  32'(busy),       32'd0);
    check("reset_full",  32'(fifo_full),  32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_ovf",   32'(ovf),        32'd0);
    RST = 1'b0;
    step();

    // Single byte 0xA5: exact line waveform, edge by edge.
    do_reset();
    pat = 8'hA5;
    sb.push_back(pat);
    drive(1'b1, pat, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    check("a5_busy_e0",  32'(busy),       32'd1);
    check("a5_count_e0", 32'(fifo_count), 32'd1);
    for (int j = 0; j < 40; j++) begin
      step();
      if (j < 4)       exp_tx = 1'b0;
      else if (j < 36) exp_tx = pat[(j - 4) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("a5_tx_%0d", j), 32'(tx), 32'(exp_tx));
    end
    check("a5_busy_last", 32'(busy), 32'd1);
    step();
    check("a5_busy_fall", 32'(busy), 32'd0);
    wait_drain("a5_drain", 100);

    // Burst of writes into a 4-deep FIFO, including drop and clear interplay.
    do_reset();
    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h06, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'h07, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].te, tbl[i].d, tbl[i].clr);
      if (tbl[i].acc) sb.push_back(tbl[i].d);
      step();
      check($sformatf("burst_count_%0d", i), 32'(fifo_count), 32'(tbl[i].cnt));
      check($sformatf("burst_full_%0d", i),  32'(fifo_full),  32'(tbl[i].full));
      check($sformatf("burst_ovf_%0d", i),   32'(ovf),        32'(tbl[i].ovf));
      check($sformatf("burst_busy_%0d", i),  32'(busy),       32'd1);
    end
    drive(1'b0, 8'h00, 1'b0);
    wait_drain("burst_drain", 400);
    check("burst_frames", 32'(starts.size()), 32'd5);
    for (int i = 1; i < starts.size(); i++) begin
      check($sformatf("burst_gap_%0d", i), 32'(starts[i] - starts[i-1]), 32'(10 * CPB));
    end

    // Write into a full FIFO on the very edge the STOP bit pops the next head.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b = 8'(8'h11 + i);
      sb.push_back(b);
      drive(1'b1, b, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    repeat (36) step();
    check("popfull_count_pre", 32'(fifo_count), 32'd4);
    check("popfull_full_pre",  32'(fifo_full),  32'd1);
    sb.push_back(8'h16);
    drive(1'b1, 8'h16, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    check("popfull_count", 32'(fifo_count), 32'd4);
    check("popfull_full",  32'(fifo_full),  32'd1);
    check("popfull_ovf",   32'(ovf),        32'd0);
    wait_drain("popfull_drain", 400);
    check("popfull_frames", 32'(starts.size()), 32'd6);

    // Reset in the middle of a data bit with bytes still queued.
    do_reset();
    drive(1'b1, 8'h55, 1'b0); step();
    drive(1'b1, 8'h66, 1'b0); step();
    drive(1'b1, 8'h77, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0);
    check("midrst_count_pre", 32'(fifo_count), 32'd2);
    repeat (12) step();
    RST = 1'b1;
    step();
    check("midrst_tx",    32'(tx),         32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_ovf",   32'(ovf),        32'd0);
    RST = 1'b0;
    f0 = frames;
    low_seen = 1'b0;
    repeat (100) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
    end
    check("midrst_quiet",  32'(low_seen), 32'd0);
    check("midrst_frames", 32'(frames),   32'(f0));

    // Nine spaced bytes walk the pointers around the 4-deep FIFO twice.
    do_reset();
    f0 = frames;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      sb.push_back(b);
      drive(1'b1, b, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0);
      repeat (45) step();
    end
    wait_drain("wrap_drain", 200);
    check("wrap_frames", 32'(frames - f0), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
